// File: rtl/mac_pe_os.sv
// mac_pe_os: output-stationary systolic MAC PE with operand forwarding and a valid/ready result drain chain.
module mac_pe_os #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int OUT_W    = 16,
  parameter bit SIGNED   = 1,
  parameter bit SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_a,
  input  logic              in_a_vld,
  input  logic              in_a_last,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_b_vld,
  output logic [DATA_W-1:0] out_a,
  output logic              out_a_vld,
  output logic              out_a_last,
  output logic [DATA_W-1:0] out_b,
  output logic              out_b_vld,
  input  logic [OUT_W-1:0]  res_in,
  input  logic              res_in_vld,
  output logic              res_in_rdy,
  output logic [OUT_W-1:0]  res_out,
  output logic              res_out_vld,
  input  logic              res_out_rdy,
  output logic              err_skew,
  output logic              err_ovf
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t r_state, w_state_nxt;
  logic [DATA_W-1:0] r_a, r_b;
  logic r_a_vld, r_a_last, r_b_vld;
  logic [ACC_W-1:0] r_acc;
  logic [OUT_W-1:0] r_pend, r_out;
  logic r_pend_vld, r_out_vld, r_err_skew, r_err_ovf;
  logic w_fire, w_last, w_emit, w_load, w_keep, w_ext, w_hi_ok;
  logic signed [DATA_W:0] w_a, w_b;
  logic signed [2*DATA_W+1:0] w_pf;
  logic [ACC_W-1:0] w_prod, w_sum;
  logic [ACC_W-OUT_W+1:0] w_hi;
  logic [OUT_W-1:0] w_clamp, w_conv;
  assign w_fire = in_a_vld & in_b_vld;
  assign w_last = in_a_last;
  assign w_emit = w_fire & w_last;
  // One extra bit lets the same signed multiply serve both operand modes
  assign w_a = {SIGNED & in_a[DATA_W-1], in_a};
  assign w_b = {SIGNED & in_b[DATA_W-1], in_b};
  assign w_pf = (2*DATA_W+2)'(w_a) * (2*DATA_W+2)'(w_b);
  assign w_prod = ACC_W'(w_pf);
  assign w_sum = (r_state == ACCUM ? r_acc : '0) + w_prod;
  assign w_ext = SIGNED & w_sum[ACC_W-1];
  assign w_hi = {w_ext, w_sum[ACC_W-1:OUT_W-1]};
  assign w_hi_ok = SIGNED ? (&w_hi | ~|w_hi) : ~|(w_hi >> 1);
  assign w_clamp = SIGNED ? {w_ext, {(OUT_W-1){~w_ext}}} : '1;
  assign w_conv = (!SATURATE || w_hi_ok) ? w_sum[OUT_W-1:0] : w_clamp;
  assign w_load = !r_out_vld | res_out_rdy;
  // Pending result that cannot move into the output register this cycle
  assign w_keep = r_pend_vld & !w_load;
  always_comb begin
    w_state_nxt = r_state;
    if (w_fire) w_state_nxt = w_last ? IDLE : ACCUM;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_a_vld    <= 1'b0;
      r_a_last   <= 1'b0;
      r_b_vld    <= 1'b0;
      r_acc      <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_err_skew <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_a        <= in_a;
      r_b        <= in_b;
      r_a_vld    <= in_a_vld;
      r_a_last   <= in_a_last;
      r_b_vld    <= in_b_vld;
      if (w_fire & !w_last) r_acc <= w_sum;
      if (w_emit & !w_keep) r_pend <= w_conv;
      r_pend_vld <= w_emit | w_keep;
      if (w_load) r_out_vld <= r_pend_vld | res_in_vld;
      if (w_load & (r_pend_vld | res_in_vld)) r_out <= r_pend_vld ? r_pend : res_in;
      r_err_skew <= r_err_skew | (in_a_vld ^ in_b_vld);
      r_err_ovf  <= r_err_ovf | (w_emit & w_keep);
    end
  end
  assign out_a       = r_a;
  assign out_a_vld   = r_a_vld;
  assign out_a_last  = r_a_last;
  assign out_b       = r_b;
  assign out_b_vld   = r_b_vld;
  assign res_in_rdy  = !reset & w_load & !r_pend_vld;
  assign res_out     = r_out;
  assign res_out_vld = r_out_vld;
  assign err_skew    = r_err_skew;
  assign err_ovf     = r_err_ovf;
endmodule

// File: tb/tb_mac_pe_os.sv
// tb_mac_pe_os: table-driven dot products on signed-saturating, signed-wrapping and unsigned PEs, plus drain-chain corner sequences.
module tb_mac_pe_os;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] a, b;
  logic a_vld, a_last, b_vld, rdy, res_in_vld;
  logic [15:0] res_in;
  logic [7:0] s_oa, s_ob, w_oa, w_ob, u_oa, u_ob;
  logic s_oav, s_oal, s_obv, s_rir, s_rov, s_esk, s_eov;
  logic w_oav, w_oal, w_obv, w_rir, w_rov, w_esk, w_eov;
  logic u_oav, u_oal, u_obv, u_rir, u_rov, u_esk, u_eov;
  logic [15:0] s_ro, w_ro, u_ro;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mac_pe_os u_sat (
    .clk(clk), .reset(reset), .in_a(a), .in_a_vld(a_vld), .in_a_last(a_last),
    .in_b(b), .in_b_vld(b_vld), .out_a(s_oa), .out_a_vld(s_oav), .out_a_last(s_oal),
    .out_b(s_ob), .out_b_vld(s_obv), .res_in(res_in), .res_in_vld(res_in_vld),
    .res_in_rdy(s_rir), .res_out(s_ro), .res_out_vld(s_rov), .res_out_rdy(rdy),
    .err_skew(s_esk), .err_ovf(s_eov));
  mac_pe_os #(.SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .in_a(a), .in_a_vld(a_vld), .in_a_last(a_last),
    .in_b(b), .in_b_vld(b_vld), .out_a(w_oa), .out_a_vld(w_oav), .out_a_last(w_oal),
    .out_b(w_ob), .out_b_vld(w_obv), .res_in(res_in), .res_in_vld(res_in_vld),
    .res_in_rdy(w_rir), .res_out(w_ro), .res_out_vld(w_rov), .res_out_rdy(rdy),
    .err_skew(w_esk), .err_ovf(w_eov));
  mac_pe_os #(.SIGNED(0)) u_uns (
    .clk(clk), .reset(reset), .in_a(a), .in_a_vld(a_vld), .in_a_last(a_last),
    .in_b(b), .in_b_vld(b_vld), .out_a(u_oa), .out_a_vld(u_oav), .out_a_last(u_oal),
    .out_b(u_ob), .out_b_vld(u_obv), .res_in(res_in), .res_in_vld(res_in_vld),
    .res_in_rdy(u_rir), .res_out(u_ro), .res_out_vld(u_rov), .res_out_rdy(rdy),
    .err_skew(u_esk), .err_ovf(u_eov));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic av, input logic bv, input logic l);
    a = va;
    b = vb;
    a_vld = av;
    b_vld = bv;
    a_last = l;
    @(negedge clk);
  endtask
  task automatic idle();
    a_vld = 1'b0;
    b_vld = 1'b0;
    a_last = 1'b0;
  endtask
  typedef struct {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    int n;
    logic [15:0] es;
    logic [15:0] ew;
    logic [15:0] eu;
  } vec_t;
  vec_t v[7];
  logic [15:0] q[$];
  logic [7:0] t3a[4];
  logic [7:0] t3b[4];
  initial begin
    v[0] = '{{8'd0, 8'd7, 8'hFE, 8'd3}, {8'd0, 8'hFF, 8'd5, 8'd4}, 3, 16'hFFFB, 16'hFFFB, 16'h0BFB};
    v[1] = '{{4{8'd127}}, {4{8'd127}}, 4, 16'h7FFF, 16'hFC04, 16'hFC04};
    v[2] = '{{4{8'h80}}, {4{8'h80}}, 4, 16'h7FFF, 16'h0000, 16'hFFFF};
    v[3] = '{{8'd0, {3{8'h80}}}, {8'd0, {3{8'd127}}}, 3, 16'h8000, 16'h4180, 16'hBE80};
    v[4] = '{32'd0, 32'd0, 1, 16'h0000, 16'h0000, 16'h0000};
    v[5] = '{{24'd0, 8'd2}, {24'd0, 8'd3}, 1, 16'h0006, 16'h0006, 16'h0006};
    v[6] = '{{16'd0, 8'hFF, 8'hFF}, {16'd0, 8'd1, 8'hFF}, 2, 16'h0000, 16'h0000, 16'hFF00};
    t3a = '{8'd1, 8'd3, 8'd5, 8'd7};
    t3b = '{8'd2, 8'd4, 8'd6, 8'd8};
    reset = 1'b1;
    a = '0;
    b = '0;
    idle();
    rdy = 1'b1;
    res_in = '0;
    res_in_vld = 1'b0;
    #12;
    chk("rst_out_vld", s_rov, 0);
    chk("rst_out_a_vld", s_oav, 0);
    chk("rst_res_in_rdy", s_rir, 0);
    chk("rst_errs", {s_esk, s_eov}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < v[i].n; k++) begin
        drive(v[i].a[k], v[i].b[k], 1'b1, 1'b1, k == v[i].n - 1);
        chk($sformatf("fwd_a v%0d", i), {s_oav, s_oal, s_oa}, {1'b1, k == v[i].n - 1, v[i].a[k]});
        chk($sformatf("fwd_b v%0d", i), {s_obv, s_ob}, {1'b1, v[i].b[k]});
      end
      idle();
      chk($sformatf("lat_early v%0d", i), s_rov, 0);
      @(negedge clk);
      chk($sformatf("vld v%0d", i), {s_rov, w_rov, u_rov}, 3'b111);
      chk($sformatf("sat v%0d", i), s_ro, v[i].es);
      chk($sformatf("wrap v%0d", i), w_ro, v[i].ew);
      chk($sformatf("uns v%0d", i), u_ro, v[i].eu);
      @(negedge clk);
      chk($sformatf("drain v%0d", i), s_rov, 0);
    end
    chk("no_err_table", {s_esk, s_eov, u_esk, u_eov}, 0);
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(t3a[c], t3b[c], 1'b1, 1'b1, c[0]);
      else begin
        idle();
        @(negedge clk);
      end
      if (s_rov) q.push_back(s_ro);
    end
    chk("b2b_count", q.size(), 2);
    chk("b2b_first", q[0], 16'd14);
    chk("b2b_second", q[1], 16'd86);
    chk("b2b_no_ovf", s_eov, 0);
    drive(8'd2, 8'd3, 1'b1, 1'b1, 1'b1);
    idle();
    res_in = 16'h0111;
    res_in_vld = 1'b1;
    rdy = 1'b0;
    #1;
    chk("own_first_rdy", s_rir, 0);
    @(negedge clk);
    chk("own_first_out", {s_rov, s_ro}, {1'b1, 16'd6});
    chk("stall_rdy", s_rir, 0);
    @(negedge clk);
    chk("stall_hold", {s_rov, s_ro}, {1'b1, 16'd6});
    rdy = 1'b1;
    #1;
    chk("up_rdy", s_rir, 1);
    @(negedge clk);
    chk("up_out", {s_rov, s_ro}, {1'b1, 16'h0111});
    res_in_vld = 1'b0;
    @(negedge clk);
    chk("up_drain", s_rov, 0);
    chk("up_no_ovf", s_eov, 0);
    rdy = 1'b0;
    drive(8'd2, 8'd3, 1'b1, 1'b1, 1'b1);
    drive(8'd4, 8'd5, 1'b1, 1'b1, 1'b1);
    drive(8'd6, 8'd7, 1'b1, 1'b1, 1'b1);
    idle();
    chk("ovf_flag", s_eov, 1);
    chk("ovf_out", {s_rov, s_ro}, {1'b1, 16'd6});
    @(negedge clk);
    chk("ovf_hold", {s_rov, s_ro}, {1'b1, 16'd6});
    rdy = 1'b1;
    @(negedge clk);
    chk("ovf_pend", {s_rov, s_ro}, {1'b1, 16'd20});
    @(negedge clk);
    chk("ovf_dropped", s_rov, 0);
    chk("ovf_sticky", s_eov, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_clears_ovf", s_eov, 0);
    drive(8'd5, 8'd5, 1'b1, 1'b1, 1'b0);
    drive(8'd9, 8'd0, 1'b1, 1'b0, 1'b1);
    drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b1);
    idle();
    chk("skew_flag", s_esk, 1);
    @(negedge clk);
    chk("skew_acc", {s_rov, s_ro}, {1'b1, 16'd26});
    @(negedge clk);
    drive(8'd5, 8'd5, 1'b1, 1'b1, 1'b0);
    idle();
    reset = 1'b1;
    #1;
    chk("mid_rst_fwd", {s_oav, s_oal, s_oa, s_obv, s_ob}, 0);
    chk("mid_rst_res", {s_rov, s_ro, s_rir}, 0);
    chk("mid_rst_err", {s_esk, s_eov}, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(8'd2, 8'd2, 1'b1, 1'b1, 1'b1);
    idle();
    @(negedge clk);
    chk("post_rst_fresh", {s_rov, s_ro}, {1'b1, 16'd4});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
